multicast_fork: RTL

Clocked, parametrised one-to-N fork with per-packet destination masking and independent (eager) output completion. A single input stream of WIDTH-bit packets is buffered in a DEPTH-entry FIFO and copied to the subset of N output channels selected by each packet's mask. Each output completes its handshake independently, and packet order is preserved on every output. It replaces fixed four-way copy stages in the PE datapath wherever a clocked valid/ready stream must fan out to a variable set of consumers.

---
 rtl/multicast_fork.sv | 98 +++++++++
 1 files changed

// File: rtl/multicast_fork.sv
// rtl/multicast_fork.sv - one-to-N masked stream fork with input FIFO and eager per-output completion
module multicast_fork #(
    parameter int WIDTH   = 4,
    parameter int N       = 4,
    parameter int DEPTH   = 2,
    parameter int MASK_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               l_valid,
    output logic               l_ready,
    input  logic [WIDTH-1:0]   l_data,
    input  logic [N-1:0]       l_mask,
    output logic [N-1:0]       r_valid,
    input  logic [N-1:0]       r_ready,
    output logic [N*WIDTH-1:0] r_data,
    output logic               busy,
    output logic               zero_drop
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [N-1:0]     mask_mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_next;
    logic [CW-1:0]    count;
    logic [N-1:0]     pending;
    logic [N-1:0]     em;
    logic [N-1:0]     fire;
    logic             nonempty;
    logic             xfer;
    logic             push;
    logic             pop;

    assign em       = (MASK_EN != 0) ? l_mask : '1;
    assign nonempty = (count != '0);
    assign l_ready  = rst_n & (count != FULL);
    assign xfer     = l_valid & l_ready;
    assign push     = xfer & (em != '0);
    assign r_valid  = pending & {N{nonempty}};
    assign fire     = r_valid & r_ready;
    // Head retires once every output it still owes has fired, including this cycle's fires.
    assign pop      = nonempty & ((pending & ~fire) == '0);
    assign rd_next  = rd_ptr + 1'b1;
    assign busy     = nonempty;

    always_comb begin
        r_data = {N{data_mem[rd_ptr]}};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= l_data;
            mask_mem[wr_ptr] <= em;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            pending   <= '0;
            zero_drop <= 1'b0;
        end else begin
            zero_drop <= xfer & (em == '0);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
            // With one entry left, a simultaneous push becomes the new head directly.
            if (pop) begin
                if (count > ONE) begin
                    pending <= mask_mem[rd_next];
                end else if (push) begin
                    pending <= em;
                end else begin
                    pending <= '0;
                end
            end else if (!nonempty && push) begin
                pending <= em;
            end else begin
                pending <= pending & ~fire;
            end
        end
    end
endmodule
